// File: rtl/act_interp_pkg.sv
// +--------------------------------------------------------------------+
// | act_interp_pkg : shared widths and stage payloads for act_interp    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package act_interp_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ADDR_W  = 4;
  localparam int REM_W       = DEF_DATA_W - DEF_ADDR_W;
  localparam int TABLE_DEPTH = (1 << DEF_ADDR_W) + 1;
  localparam int PROD_W      = DEF_DATA_W + 1 + REM_W;

  typedef struct packed {
    logic signed [DEF_DATA_W-1:0] base;
    logic signed [DEF_DATA_W-1:0] nxt;
    logic        [REM_W-1:0]      rem;
    logic                         bypass;
    logic signed [DEF_DATA_W-1:0] x;
  } s1_payload_t;

  typedef struct packed {
    logic signed [PROD_W-1:0]     prod;
    logic signed [DEF_DATA_W-1:0] base;
    logic                         bypass;
    logic signed [DEF_DATA_W-1:0] x;
  } s2_payload_t;

endpackage

`default_nettype wire

// File: rtl/act_interp_table.sv
// +--------------------------------------------------------------------+
// | act_interp_table : sample register file, 1 write / 2 comb reads     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module act_interp_table #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W:0]   i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W:0]   i_raddr0,
  input  logic [ADDR_W:0]   i_raddr1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1
);

  localparam int c_DEPTH = (1 << ADDR_W) + 1;

  logic [DATA_W-1:0] r_mem [c_DEPTH];

  // Contents deliberately survive reset; software reloads after power-up.
  always_ff @(posedge clk) begin
    if (i_we && (i_waddr < (ADDR_W+1)'(c_DEPTH))) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata0 = r_mem[i_raddr0];
  assign o_rdata1 = r_mem[i_raddr1];

endmodule

`default_nettype wire

// File: rtl/act_interp_pipe.sv
// +--------------------------------------------------------------------+
// | act_interp_pipe : 3-stage stallable table-interpolating activation  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module act_interp_pipe
  import act_interp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              lut_we,
  input  logic [ADDR_W:0]   lut_addr,
  input  logic [DATA_W-1:0] lut_wdata
);

  localparam int c_REM_W  = DATA_W - ADDR_W;
  localparam int c_PROD_W = DATA_W + 1 + c_REM_W;

  logic                       w_advance;
  logic [DATA_W-1:0]          w_u;
  logic [ADDR_W-1:0]          w_idx;
  logic [c_REM_W-1:0]         w_rem;
  logic [ADDR_W:0]            w_raddr0;
  logic [ADDR_W:0]            w_raddr1;
  logic [DATA_W-1:0]          w_base;
  logic [DATA_W-1:0]          w_next;
  logic signed [DATA_W:0]     w_diff;
  logic signed [c_PROD_W-1:0] w_prod;
  logic signed [c_PROD_W-1:0] w_shift;
  logic signed [c_PROD_W-1:0] w_sum;
  logic [DATA_W-1:0]          w_result;

  s1_payload_t       r_s1;
  s2_payload_t       r_s2;
  logic              r_s1_valid;
  logic              r_s2_valid;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;

  assign w_advance = ~r_out_valid | out_ready;
  assign in_ready  = w_advance | rst;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // Adding 2^(DATA_W-1) to a two's-complement value is just an MSB flip.
  assign w_u      = {~in_data[DATA_W-1], in_data[DATA_W-2:0]};
  assign w_idx    = w_u[DATA_W-1:c_REM_W];
  assign w_rem    = w_u[c_REM_W-1:0];
  assign w_raddr0 = {1'b0, w_idx};
  assign w_raddr1 = w_raddr0 + {{ADDR_W{1'b0}}, 1'b1};

  act_interp_table #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_table (
    .clk      (clk),
    .i_we     (lut_we),
    .i_waddr  (lut_addr),
    .i_wdata  (lut_wdata),
    .i_raddr0 (w_raddr0),
    .i_raddr1 (w_raddr1),
    .o_rdata0 (w_base),
    .o_rdata1 (w_next)
  );

  assign w_diff   = {r_s1.nxt[DATA_W-1], r_s1.nxt} - {r_s1.base[DATA_W-1], r_s1.base};
  assign w_prod   = c_PROD_W'(w_diff) * $signed({{(c_PROD_W-c_REM_W){1'b0}}, r_s1.rem});
  assign w_shift  = $signed(r_s2.prod) >>> c_REM_W;
  assign w_sum    = c_PROD_W'($signed(r_s2.base)) + w_shift;
  assign w_result = r_s2.bypass ? r_s2.x : w_sum[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_advance) begin
      r_s1_valid  <= in_valid;
      r_s2_valid  <= r_s1_valid;
      r_out_valid <= r_s2_valid;
      r_out_data  <= w_result;
    end
  end

  always_ff @(posedge clk) begin
    if (w_advance) begin
      r_s1.base   <= w_base;
      r_s1.nxt    <= w_next;
      r_s1.rem    <= w_rem;
      r_s1.bypass <= in_bypass;
      r_s1.x      <= in_data;
      r_s2.prod   <= w_prod;
      r_s2.base   <= r_s1.base;
      r_s2.bypass <= r_s1.bypass;
      r_s2.x      <= r_s1.x;
    end
  end

endmodule

`default_nettype wire
